// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage controller that maps byte/half/word loads and stores
// onto a word-only data memory, with read-modify-write for sub-word stores.
`default_nettype none

module dmem_access_unit #(
  parameter int MEM_BYTES_LOG2 = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] LD_FMT = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] FAULT  = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic        cap_sext;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        req_fault;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Fault decode works on the live request, since the branch is taken at the capture edge.
  always_comb begin
    req_fault = ((addr >> MEM_BYTES_LOG2) != 32'd0);
    case (size)
      SZ_BYTE: req_fault = req_fault;
      SZ_HALF: req_fault = req_fault | addr[0];
      SZ_WORD: req_fault = req_fault | (addr[1:0] != 2'b00);
      default: req_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_fault)
            next_state = FAULT;
          else if (we && size == SZ_WORD)
            next_state = WR;
          else
            next_state = RD;
        end
      end
      RD:      next_state = cap_we ? RMW_WR : LD_FMT;
      LD_FMT:  next_state = IDLE;
      WR:      next_state = IDLE;
      RMW_WR:  next_state = IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_read  = (state == RD);
    mem_write = (state == WR) || (state == RMW_WR);
    mem_din   = 32'd0;
    if (state == WR)
      mem_din = cap_wdata;
    else if (state == RMW_WR)
      mem_din = merged;
  end

  assign mem_address = {cap_addr[31:2], 2'b00};

  always_comb begin
    case (cap_addr[1:0])
      2'd0:    lane_byte = mem_dout[7:0];
      2'd1:    lane_byte = mem_dout[15:8];
      2'd2:    lane_byte = mem_dout[23:16];
      default: lane_byte = mem_dout[31:24];
    endcase
    lane_half = cap_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (cap_size)
      SZ_BYTE: load_val = {{24{cap_sext & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_val = {{16{cap_sext & lane_half[15]}}, lane_half};
      default: load_val = mem_dout;
    endcase
  end

  always_comb begin
    merged = mem_dout;
    if (cap_size == SZ_BYTE) begin
      case (cap_addr[1:0])
        2'd0:    merged[7:0]   = cap_wdata[7:0];
        2'd1:    merged[15:8]  = cap_wdata[7:0];
        2'd2:    merged[23:16] = cap_wdata[7:0];
        default: merged[31:24] = cap_wdata[7:0];
      endcase
    end else if (cap_size == SZ_HALF) begin
      if (cap_addr[1])
        merged[31:16] = cap_wdata[15:0];
      else
        merged[15:0] = cap_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_size  <= 2'b00;
      cap_sext  <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
    end else if (state == IDLE && req) begin
      cap_we    <= we;
      cap_size  <= size;
      cap_sext  <= sign_ext;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end
  end

  // Completion flags pulse for a single cycle; rdata only moves on a successful load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        FAULT: begin
          done <= 1'b1;
          err  <= 1'b1;
        end
        LD_FMT: begin
          done  <= 1'b1;
          rdata <= load_val;
        end
        WR, RMW_WR: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed self-checking bench with a behavioural 1-cycle data memory.
`default_nettype none

module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  int checks;
  int errors;

  logic [31:0] mem [0:2047];

  dmem_access_unit #(.MEM_BYTES_LOG2(13)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-only memory: registered read, write has priority.
  always @(posedge clk) begin
    if (mem_write === 1'b1)
      mem[mem_address[12:2]] <= mem_din;
    else if (mem_read === 1'b1)
      mem_dout <= mem[mem_address[12:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge where done is seen (or after the bound).
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int nrd, output int nwr,
                       output logic [31:0] wadr, output logic [31:0] wdin,
                       output logic err_seen);
    lat = -1; nrd = 0; nwr = 0; wadr = 32'hxxxxxxxx; wdin = 32'hxxxxxxxx; err_seen = 1'bx;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_read === 1'b1) nrd++;
      if (mem_write === 1'b1) begin
        nwr++;
        wadr = mem_address;
        wdin = mem_din;
      end
      if (done === 1'b1) begin
        lat = n;
        err_seen = err;
        break;
      end
    end
  endtask

  int          lat, nrd, nwr;
  logic [31:0] wadr, wdin;
  logic        e;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_dout = 32'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;

    // Asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    #10 rst = 1'b0;
    @(negedge clk);

    // Word store then word load
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, nrd, nwr, wadr, wdin, e);
    chk("sw_lat", lat, 2);
    chk("sw_strobes", {nrd[15:0], nwr[15:0]}, {16'd0, 16'd1});
    chk("sw_addr", wadr, 32'h10);
    chk("sw_din", wdin, 32'hDEADBEEF);
    chk("sw_err", {31'd0, e}, 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lw_lat", lat, 3);
    chk("lw_strobes", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd0});
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);

    // Lane extraction
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, lat, nrd, nwr, wadr, wdin, e);
    do_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lb_13", rdata, 32'hFFFFFF80);
    do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lbu_13", rdata, 32'h00000080);
    do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lh_12", rdata, 32'hFFFF80FF);
    do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lhu_10", rdata, 32'h00007F01);
    do_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lb_11", rdata, 32'h0000007F);

    // Read-modify-write
    do_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, lat, nrd, nwr, wadr, wdin, e);
    chk("sb_lat", lat, 3);
    chk("sb_strobes", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
    chk("sb_din", wdin, 32'h80FFAA01);
    chk("sb_addr", wadr, 32'h10);
    chk("sb_rdata_kept", rdata, 32'h0000007F);
    do_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, nrd, nwr, wadr, wdin, e);
    chk("sh_din", wdin, 32'h1234AA01);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("lw_after_rmw", rdata, 32'h1234AA01);

    // Faults: 2-cycle latency, err set, no strobes, rdata kept
    do_op(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("f_lw11", {lat[7:0], nrd[7:0], nwr[7:0], 7'd0, e}, {8'd2, 8'd0, 8'd0, 8'd1});
    @(negedge clk);
    chk("f_err_one_cycle", {30'd0, done, err}, 32'd0);
    do_op(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, lat, nrd, nwr, wadr, wdin, e);
    chk("f_sh13", {lat[7:0], nrd[7:0], nwr[7:0], 7'd0, e}, {8'd2, 8'd0, 8'd0, 8'd1});
    do_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("f_size11", {lat[7:0], nrd[7:0], nwr[7:0], 7'd0, e}, {8'd2, 8'd0, 8'd0, 8'd1});
    do_op(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("f_range", {lat[7:0], nrd[7:0], nwr[7:0], 7'd0, e}, {8'd2, 8'd0, 8'd0, 8'd1});
    chk("f_rdata_kept", rdata, 32'h1234AA01);
    chk("f_mem_kept", mem[4], 32'h1234AA01);

    // req during RD is ignored
    we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; req = 1'b1;
    @(posedge clk);
    #1 we = 1'b1; addr = 32'h20; wdata = 32'h55555555;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_ign_done", {30'd0, done, err}, 32'd2);
    chk("busy_ign_rdata", rdata, 32'h1234AA01);
    @(negedge clk);
    chk("busy_ign_idle", {31'd0, busy}, 32'd0);
    chk("busy_ign_mem20", mem[8], 32'd0);

    // Back-to-back: second request issued on the done cycle
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, lat, nrd, nwr, wadr, wdin, e);
    chk("b2b_sw_lat", lat, 2);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("b2b_lw_lat", lat, 3);
    chk("b2b_lw_rdata", rdata, 32'h11112222);

    // Reset while in RMW_WR aborts the write
    we = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'hCC; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_pre_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_strobes", {29'd0, mem_write, mem_read, busy}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", {30'd0, done, busy}, 32'd0);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, nrd, nwr, wadr, wdin, e);
    chk("abort_word_kept", rdata, 32'h11112222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator-side controller that drives the word-only, 8 KB data memory (1-cycle registered read, write-priority) on behalf of the pipeline MEM stage.
- Turns byte, halfword and word load/store requests into word accesses.
- Loads: extracts and extends the addressed lane.
- Sub-word stores: read-modify-write sequence.
- Faults on misaligned, reserved-size or out-of-range requests without touching memory.

Parameters:
- MEM_BYTES_LOG2, 13, log2 of data memory size in bytes; address bits at and above this index must be zero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; byte/half taken from low bits
- busy  out  1  high whenever FSM not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = request faulted
- rdata  out  32  load result; holds until next successful load
- mem_address  out  32  to memory; {captured addr[31:2], 2'b00}
- mem_din  out  32  to memory write data
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_dout  in  32  from memory; valid the cycle after mem_read

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs and captured request registers 0.
- Reset mid-operation forces IDLE; mem_read/mem_write drop immediately (decoded from state); no done is produced.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], k = addr[1:0]; half at addr[1]=0 is bits [15:0], at addr[1]=1 is bits [31:16].
- FSM states: IDLE, RD, LD_FMT, WR, RMW_WR, FAULT.
- IDLE, req=1: capture we/size/sign_ext/addr/wdata, then branch:
  - fault if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠0, or any addr[31:MEM_BYTES_LOG2]≠0 → FAULT.
  - else store word → WR.
  - else load or sub-word store → RD.
- FAULT: done<=1, err<=1 at edge; → IDLE. No memory strobe.
- RD: mem_read=1 → LD_FMT (load) or RMW_WR (store).
- LD_FMT: mem_dout valid. At the edge:
  - rdata<=extracted lane, extended per sign_ext; word ignores sign_ext.
  - done<=1, err<=0; → IDLE.
- WR: mem_write=1, mem_din=wdata. At edge done<=1; → IDLE.
- RMW_WR: mem_write=1, mem_din = mem_dout with the addressed lane replaced by wdata[7:0] or wdata[15:0]. At edge done<=1; → IDLE.
- mem_read and mem_write are never both 1; both 0 in IDLE/FAULT/LD_FMT.
- Latency, req edge to done high: word store 2 cycles, fault 2 cycles, load 3 cycles, sub-word store 3 cycles.
- done and err are high for exactly one cycle; err=0 on every non-fault done.
- req while busy is ignored (not queued). req in the cycle done is high is accepted, because the FSM is already in IDLE.
- rdata is not modified by stores or faults.

Test Plan:
- Reset then idle: rst pulse mid-cycle → all outputs 0 asynchronously; busy=0.
- Word store/load: sw addr=0x10 wdata=0xDEADBEEF.
  - done 2 cycles later, mem_write one cycle with mem_address=0x10.
  - lw 0x10 → done 3 cycles later, rdata=0xDEADBEEF, err=0.
- Byte lanes: memory word 0x10 = 0x80FF7F01.
  - lb 0x13 → 0xFFFFFF80.
  - lbu 0x13 → 0x00000080.
  - lh 0x12 → 0xFFFF80FF.
  - lhu 0x10 → 0x00007F01.
- Read-modify-write:
  - sb addr=0x11 wdata=0x000000AA on 0x80FF7F01 → mem_din=0x80FFAA01, one RD then one write cycle.
  - sh addr=0x12 wdata=0x1234 → word becomes 0x1234AA01.
- Faults: each → done+err 2 cycles later, no mem_read/mem_write, rdata unchanged.
  - lw 0x11.
  - sh 0x13.
  - size=11.
  - addr=0x2000 with MEM_BYTES_LOG2=13.
- Busy/abort:
  - req during RD ignored.
  - rst asserted in RMW_WR → mem_write drops immediately, no done, target word unchanged.
  - back-to-back req on the done cycle accepted.
